abc_display_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for the display IP. It generalises the fixed four-register RW slave to N registers with per-register access modes (RW, RO, W1C), byte strobes, error responses and hardware status inputs. It sits between the AXI interconnect (driven by the master VIP in simulation) and the display timing/pixel logic.

---
 rtl/abc_display_regbank.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_abc_display_regbank.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abc_display_regbank.sv
// -----------------------------------------------------------------------------
// abc_display_regbank
//   AXI4-Lite slave register bank for the display IP. C_NUM_REGS registers of
//   C_DATA_WIDTH bits, each one of three kinds:
//     RW  : bus writable with byte strobes, read back as stored
//     RO  : writes rejected with SLVERR, reads return the hw_in slice
//     W1C : sticky status; hw_set sets bits, writing 1 clears them
//   RO wins when a register is flagged both RO and W1C.
//
// Ports
//   ACLK / ARESETN     clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*    write address / data / response channels
//   S_AXI_AR*/R*       read address / data channels
//   reg_q              flat register contents, register i at slice i
//   hw_in              values returned for RO registers
//   hw_set             per-bit set pulses for W1C registers (applied every cycle)
//   wr_pulse           one-cycle pulse after register i takes an OKAY write
// -----------------------------------------------------------------------------
module abc_display_regbank #(
    parameter int           C_DATA_WIDTH = 32,
    parameter int           C_NUM_REGS   = 16,
    parameter int           C_ADDR_WIDTH = 8,
    parameter logic [255:0] C_RO_MASK    = '0,
    parameter logic [255:0] C_W1C_MASK   = '0
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]  reg_q,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]  hw_in,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]  hw_set,
    output logic [C_NUM_REGS-1:0]               wr_pulse
);

    localparam int STRB_W   = C_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // Register kind vectors; W1C is masked by RO so RO takes priority.
    logic [C_NUM_REGS-1:0] ro_vec, w1c_vec;
    assign ro_vec  = C_RO_MASK[C_NUM_REGS-1:0];
    assign w1c_vec = C_W1C_MASK[C_NUM_REGS-1:0] & ~ro_vec;

    // Address decode: one-hot select per register, all-zero means out of range.
    logic [IDX_W-1:0]      widx, ridx;
    logic [C_NUM_REGS-1:0] wsel, rsel;
    logic                  w_oor, r_oor, w_ro;

    assign widx = S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
    assign ridx = S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];

    always_comb begin
        wsel = '0;
        rsel = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wsel[i] = (widx == IDX_W'(i));
            rsel[i] = (ridx == IDX_W'(i));
        end
    end

    assign w_oor = ~|wsel;
    assign r_oor = ~|rsel;
    assign w_ro  = |(wsel & ro_vec);

    // ------------------------------------------------------------------ write
    w_state_t w_state;
    logic     awready, wready, bvalid;
    logic [1:0] bresp;
    logic     w_fire;
    logic [C_NUM_REGS-1:0] wr_en;

    // Handshake completes on the edge where the registered READY pulse meets
    // both VALIDs still held by the master.
    assign w_fire = (w_state == W_IDLE) && awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_en  = {C_NUM_REGS{w_fire}} & wsel & ~ro_vec;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_en;
            case (w_state)
                W_IDLE: begin
                    if (awready) begin
                        // READY is a single-cycle pulse whether or not the
                        // master kept both VALIDs up.
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        if (S_AXI_AWVALID && S_AXI_WVALID) begin
                            bresp   <= (w_oor || w_ro) ? RESP_SLVERR : RESP_OKAY;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end
                    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid  <= 1'b0;
                        bresp   <= RESP_OKAY;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;

    // -------------------------------------------------------------- registers
    logic [C_NUM_REGS-1:0][C_DATA_WIDTH-1:0] reg_arr;

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
        abc_display_regbank_cell #(
            .C_DATA_WIDTH (C_DATA_WIDTH),
            .C_IS_RO      (C_RO_MASK[g]),
            .C_IS_W1C     (C_W1C_MASK[g])
        ) u_cell (
            .clk    (ACLK),
            .rst_n  (ARESETN),
            .wr_en  (wr_en[g]),
            .wdata  (S_AXI_WDATA),
            .wstrb  (S_AXI_WSTRB),
            .hw_set (hw_set[g*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .q      (reg_arr[g])
        );
    end

    assign reg_q = reg_arr;

    // ------------------------------------------------------------------- read
    logic [C_DATA_WIDTH-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (rsel[i])
                rd_mux = ro_vec[i] ? hw_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : reg_arr[i];
        end
    end

    r_state_t r_state;
    logic     arready, rvalid;
    logic [1:0] rresp;
    logic [C_DATA_WIDTH-1:0] rdata;

    // Data is captured from the current register state, so a write landing
    // on the same edge is not visible to this read.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arready && S_AXI_ARVALID) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rdata   <= rd_mux;
                        rresp   <= r_oor ? RESP_SLVERR : RESP_OKAY;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// -----------------------------------------------------------------------------
// abc_display_regbank_cell
//   One register of the bank. Kind is fixed by C_IS_RO / C_IS_W1C.
//   RO cells never change (stay at reset value); W1C cells OR in hw_set every
//   cycle after the write-1-clear, so a same-cycle set beats the clear.
//
// Ports
//   clk / rst_n   clock, asynchronous active-low reset
//   wr_en         accepted OKAY write to this register
//   wdata/wstrb   bus write data and byte enables
//   hw_set        per-bit set pulses (W1C only)
//   q             register value
// -----------------------------------------------------------------------------
module abc_display_regbank_cell #(
    parameter int C_DATA_WIDTH = 32,
    parameter bit C_IS_RO      = 1'b0,
    parameter bit C_IS_W1C     = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic [C_DATA_WIDTH-1:0]   hw_set,
    output logic [C_DATA_WIDTH-1:0]   q
);

    logic [C_DATA_WIDTH-1:0] bmask, q_n;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < C_DATA_WIDTH/8; b++)
            bmask[b*8 +: 8] = {8{wstrb[b]}};
    end

    always_comb begin
        q_n = q;
        if (C_IS_RO) begin
            q_n = q;
        end else if (C_IS_W1C) begin
            if (wr_en)
                q_n = q & ~(wdata & bmask);
            q_n = q_n | hw_set;
        end else if (wr_en) begin
            q_n = (q & ~bmask) | (wdata & bmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= q_n;
    end

endmodule

// File: tb/tb_abc_display_regbank.sv
module tb_abc_display_regbank;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 8;
    localparam int SW = DW / 8;
    // reg1 RO, reg2 and reg5 W1C, reg6 flagged both (RO must win)
    localparam logic [255:0] RO_M  = 256'h42;
    localparam logic [255:0] W1C_M = 256'h64;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [AW-1:0]     S_AXI_AWADDR = '0;
    logic [2:0]        S_AXI_AWPROT = '0;
    logic              S_AXI_AWVALID = 1'b0;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA = '0;
    logic [SW-1:0]     S_AXI_WSTRB = '0;
    logic              S_AXI_WVALID = 1'b0;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY = 1'b0;
    logic [AW-1:0]     S_AXI_ARADDR = '0;
    logic [2:0]        S_AXI_ARPROT = '0;
    logic              S_AXI_ARVALID = 1'b0;
    logic              S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY = 1'b0;
    logic [NR*DW-1:0]  reg_q;
    logic [NR*DW-1:0]  hw_in = '0;
    logic [NR*DW-1:0]  hw_set = '0;
    logic [NR-1:0]     wr_pulse;

    abc_display_regbank #(
        .C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW),
        .C_RO_MASK(RO_M), .C_W1C_MASK(W1C_M)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_q(reg_q), .hw_in(hw_in), .hw_set(hw_set), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------------------------------------------------------- model
    logic [DW-1:0] mdl [NR];
    int            exp_pulse [NR];
    int            seen_pulse [NR];

    always @(negedge ACLK)
        for (int i = 0; i < NR; i++)
            if (wr_pulse[i] === 1'b1) seen_pulse[i]++;

    function automatic bit is_ro(int i);
        return RO_M[i];
    endfunction

    function automatic bit is_w1c(int i);
        return !RO_M[i] && W1C_M[i];
    endfunction

    function automatic logic [DW-1:0] byte_mask(logic [SW-1:0] s);
        logic [DW-1:0] m = '0;
        for (int b = 0; b < SW; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Bus write with hw_set pulses applied on the same clock edge.
    task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s,
                               input logic [NR*DW-1:0] hwv, output logic [1:0] resp);
        logic [DW-1:0] m = byte_mask(s);
        if (idx >= NR || is_ro(idx)) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            exp_pulse[idx]++;
            if (is_w1c(idx)) mdl[idx] = mdl[idx] & ~(d & m);
            else             mdl[idx] = (mdl[idx] & ~m) | (d & m);
        end
        for (int i = 0; i < NR; i++)
            if (is_w1c(i)) mdl[i] = mdl[i] | hwv[i*DW +: DW];
    endtask

    function automatic logic [DW-1:0] model_rdata(int idx);
        if (idx >= NR)  return '0;
        if (is_ro(idx)) return hw_in[idx*DW +: DW];
        return mdl[idx];
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    // ---------------------------------------------------------- bus drivers
    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input logic [NR*DW-1:0] hwv,
                             output logic [1:0] resp, output bit ok);
        ok = 0; resp = 2'bxx;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin
                hw_set = hwv;
                @(posedge ACLK); #1;
                hw_set = '0;
                ok = 1;
                break;
            end
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        if (ok) begin
            ok = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge ACLK);
                if (S_AXI_BVALID) begin resp = S_AXI_BRESP; ok = 1; break; end
            end
            S_AXI_BREADY = 1; @(posedge ACLK); #1; S_AXI_BREADY = 0;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [1:0] resp, output bit ok, output bit lat1);
        ok = 0; lat1 = 0; d = 'x; resp = 2'bxx;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin @(posedge ACLK); #1; ok = 1; break; end
        end
        S_AXI_ARVALID = 0;
        if (ok) begin
            ok = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge ACLK);
                if (S_AXI_RVALID) begin
                    d = S_AXI_RDATA; resp = S_AXI_RRESP; ok = 1; lat1 = (c == 0);
                    break;
                end
            end
            S_AXI_RREADY = 1; @(posedge ACLK); #1; S_AXI_RREADY = 0;
        end
    endtask

    // Write with response compared against the model.
    task automatic chk_write(input string nm, input int idx, input logic [1:0] lo,
                             input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic [NR*DW-1:0] hwv);
        logic [1:0] got, exp;
        bit ok;
        axi_write(AW'(idx * SW) | AW'(lo), d, s, hwv, got, ok);
        model_write(idx, d, s, hwv, exp);
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL %s bresp idx=%0d: got %b (handshake=%0d) want %b", nm, idx, got, ok, exp);
        end
        n_cmp++;
        if (reg_q !== model_flat()) begin
            n_err++;
            $display("FAIL %s reg_q idx=%0d: got %h want %h", nm, idx, reg_q, model_flat());
        end
    endtask

    task automatic chk_read(input string nm, input int idx, input logic [1:0] lo);
        logic [DW-1:0] d, ed;
        logic [1:0] r, er;
        bit ok, lat1;
        ed = model_rdata(idx);
        er = (idx >= NR) ? 2'b10 : 2'b00;
        axi_read(AW'(idx * SW) | AW'(lo), d, r, ok, lat1);
        n_cmp++;
        if (!ok || !lat1 || d !== ed || r !== er) begin
            n_err++;
            $display("FAIL %s read idx=%0d: got %h/%b ok=%0d lat1=%0d want %h/%b",
                     nm, idx, d, r, ok, lat1, ed, er);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #1;
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
             S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, reg_q, wr_pulse} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero, reg_q=%h rdata=%h", reg_q, S_AXI_RDATA);
        end
        ARESETN = 1;
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic test_basic();
        int ids [4] = '{0, 3, 4, 7};
        for (int k = 0; k < 4; k++) chk_write("basic", ids[k], 2'd0, DW'(k + 1), 4'hF, '0);
        for (int k = 0; k < 4; k++) chk_read("basic", ids[k], 2'd0);
        repeat (2) @(posedge ACLK);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seen_pulse[ids[k]] !== 1) begin
                n_err++;
                $display("FAIL basic wr_pulse idx=%0d: got %0d want 1", ids[k], seen_pulse[ids[k]]);
            end
        end
    endtask

    task automatic test_strobe();
        chk_write("strobe", 0, 2'd0, 32'hAABBCCDD, 4'hF, '0);
        chk_write("strobe", 0, 2'd2, 32'h11223344, 4'b0101, '0);
        n_cmp++;
        if (reg_q[0 +: DW] !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL strobe value: got %h want aa22cc44", reg_q[0 +: DW]);
        end
        chk_read("strobe", 0, 2'd1);
    endtask

    task automatic test_w1c();
        logic [NR*DW-1:0] hv = '0;
        hv[2*DW +: DW] = 32'h0000_00F0;
        // set-only pulse, then the clear
        @(posedge ACLK); #1; hw_set = hv; @(posedge ACLK); #1; hw_set = '0;
        for (int i = 0; i < NR; i++) if (is_w1c(i)) mdl[i] |= hv[i*DW +: DW];
        chk_write("w1c_clear", 2, 2'd0, 32'h30, 4'hF, '0);
        n_cmp++;
        if (reg_q[2*DW +: DW] !== 32'hC0) begin
            n_err++;
            $display("FAIL w1c_clear value: got %h want c0", reg_q[2*DW +: DW]);
        end
        hv[2*DW +: DW] = 32'h10;
        chk_write("w1c_race", 2, 2'd0, 32'h10, 4'hF, hv);
        n_cmp++;
        if (reg_q[2*DW +: DW] !== 32'hD0) begin
            n_err++;
            $display("FAIL w1c_race set_wins: got %h want d0", reg_q[2*DW +: DW]);
        end
        chk_read("w1c", 2, 2'd0);
    endtask

    task automatic test_ro_oor();
        chk_write("ro", 1, 2'd0, 32'h1234_5678, 4'hF, '0);
        chk_read("ro", 1, 2'd0);
        chk_write("ro_w1c_both", 6, 2'd0, 32'hFFFF_FFFF, 4'hF, '0);
        chk_read("ro_w1c_both", 6, 2'd0);
        chk_write("oor", 16, 2'd0, 32'hFFFF_FFFF, 4'hF, '0);
        chk_read("oor", 16, 2'd0);
        chk_read("oor_top", 63, 2'd3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int idx = $urandom_range(0, 11);
            logic [1:0] lo = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                logic [NR*DW-1:0] hv;
                for (int i = 0; i < NR; i++) hv[i*DW +: DW] = $urandom & $urandom & $urandom;
                chk_write("rand", idx, lo, $urandom, 4'($urandom), hv);
            end else begin
                chk_read("rand", idx, lo);
            end
        end
        for (int i = 0; i < NR; i++) begin
            n_cmp++;
            if (seen_pulse[i] !== exp_pulse[i]) begin
                n_err++;
                $display("FAIL rand wr_pulse idx=%0d: got %0d want %0d", i, seen_pulse[i], exp_pulse[i]);
            end
        end
    endtask

    task automatic test_stall_reset();
        logic [DW-1:0] exp_rd = model_rdata(0);
        logic [1:0] dummy;
        bit got_ar = 0, got_aw = 0, bad = 0;
        S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1;
        for (int c = 0; c < 20 && !got_ar; c++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin @(posedge ACLK); #1; got_ar = 1; end
        end
        S_AXI_ARADDR = 8'h0C;   // new request held, must not be taken
        S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h5A5A_0F0F; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        for (int c = 0; c < 20 && !got_aw; c++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin @(posedge ACLK); #1; got_aw = 1; end
        end
        model_write(0, 32'h5A5A_0F0F, 4'hF, '0, dummy);
        S_AXI_AWADDR = 8'h0C;
        n_cmp++;
        if (!got_ar || !got_aw) begin
            n_err++;
            $display("FAIL stall handshake: ar=%0d aw=%0d want 1/1", got_ar, got_aw);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            if (!S_AXI_BVALID || S_AXI_BRESP !== 2'b00 || !S_AXI_RVALID || S_AXI_RDATA !== exp_rd
                || S_AXI_RRESP !== 2'b00 || S_AXI_AWREADY || S_AXI_ARREADY) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL stall hold: bvalid=%b rvalid=%b rdata=%h want 1/1/%h, readies %b%b want 00",
                     S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, exp_rd, S_AXI_AWREADY, S_AXI_ARREADY);
        end
        @(posedge ACLK); #1;
        ARESETN = 0;
        #1;
        n_cmp++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
             S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, reg_q, wr_pulse} !== '0) begin
            n_err++;
            $display("FAIL midreset outputs: bvalid=%b rvalid=%b rdata=%h reg_q=%h",
                     S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, reg_q);
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        repeat (2) @(posedge ACLK); #1;
        ARESETN = 1;
        repeat (2) @(posedge ACLK); #1;
        chk_read("after_reset", 0, 2'd0);
        chk_write("after_reset", 3, 2'd0, 32'h0000_BEEF, 4'h3, '0);
        chk_read("after_reset", 3, 2'd0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            mdl[i] = '0; exp_pulse[i] = 0; seen_pulse[i] = 0;
            hw_in[i*DW +: DW] = $urandom;
        end
        hw_in[1*DW +: DW] = 32'hDEADBEEF;
        test_reset();
        test_basic();
        test_strobe();
        test_w1c();
        test_ro_oor();
        test_random();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
